// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin between two pixel writers,
// plus a whole-buffer fill engine that owns the port while clearing.
module fb_write_arbiter #(
    parameter int NPIX = 307200,
    parameter int AW   = 19,
    parameter int DW   = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          gnt0,
    output logic          gnt1,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_colour,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          addr_err
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);
    localparam logic [AW:0]   NPIX_W = (AW + 1)'(NPIX);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [DW-1:0] colour;
    logic          last1;
    logic          acc;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    logic          in_range;

    // Grants are gated by reset so the port is silent while held in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (HRESETn && state == IDLE) begin
            if (req0 && req1) begin
                gnt0 = last1;
                gnt1 = !last1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign acc      = gnt0 | gnt1;
    assign acc_addr = gnt1 ? addr1 : addr0;
    assign acc_data = gnt1 ? data1 : data0;
    assign in_range = {1'b0, acc_addr} < NPIX_W;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clear_start) state_nxt = CLEAR;
            CLEAR:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            colour    <= '0;
            last1     <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            mem_we   <= 1'b0;
            addr_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        last1 <= gnt1;
                        if (in_range) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= acc_addr;
                            mem_wdata <= acc_data;
                        end else begin
                            addr_err <= 1'b1;
                        end
                    end
                    if (clear_start) begin
                        colour <= clear_colour;
                        cnt    <= '0;
                    end
                end
                CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= cnt;
                    mem_wdata <= colour;
                    // Stop at the last location; never wrap into a second pass.
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign clear_busy = (state != IDLE);
    assign clear_done = (state == DONE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter built with a 16-pixel framebuffer.
module tb_fb_write_arbiter;

    localparam int NPIX = 16;
    localparam int AW   = 5;
    localparam int DW   = 8;

    typedef struct {
        logic          err;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] data0 = '0;
    logic [DW-1:0] data1 = '0;
    logic          gnt0;
    logic          gnt1;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_colour = '0;
    logic          clear_busy;
    logic          clear_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          addr_err;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    logic fill_pending = 1'b0;

    fb_write_arbiter #(.NPIX(NPIX), .AW(AW), .DW(DW)) dut (
        .HCLK        (clk),
        .HRESETn     (rst_n),
        .req0        (req0),
        .addr0       (addr0),
        .data0       (data0),
        .req1        (req1),
        .addr1       (addr1),
        .data1       (data1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .clear_start (clear_start),
        .clear_colour(clear_colour),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pop/compare outputs of the previous accept, then record this cycle's.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we || addr_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_wr", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, !e.err});
                    if (!e.err) begin
                        chk("mem_addr", {27'd0, mem_addr}, {27'd0, e.addr});
                        chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
                    end
                end
            end
            if (gnt0 && gnt1) chk("both_gnt", 1, 0);
            if (clear_busy) begin
                busy_cnt++;
                chk("busy_gnt", {31'd0, gnt0 | gnt1}, 0);
            end
            if (clear_done) done_cnt++;
            if (gnt0 && req0)
                q.push_back('{err: (int'(addr0) >= NPIX), addr: addr0, data: data0});
            if (gnt1 && req1)
                q.push_back('{err: (int'(addr1) >= NPIX), addr: addr1, data: data1});
            if (clear_start && fill_pending) begin
                for (int i = 0; i < NPIX; i++)
                    q.push_back('{err: 1'b0, addr: AW'(i), data: clear_colour});
                fill_pending = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns number of cycles the request waited.
    task automatic send(input int port, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int waited);
        waited = 0;
        if (port == 0) begin req0 = 1'b1; addr0 = a; data0 = d; end
        else begin req1 = 1'b1; addr1 = a; data1 = d; end
        forever begin
            @(negedge clk);
            if ((port == 0) ? gnt0 : gnt1) break;
            waited++;
            if (waited > 50) begin
                chk("gnt_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic start_clear(input logic [DW-1:0] c);
        busy_cnt = 0;
        done_cnt = 0;
        fill_pending = 1'b1;
        clear_start = 1'b1;
        clear_colour = c;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
    endtask

    initial begin
        int w;
        req0 = 1'b1;
        #12;
        chk("rst_gnt0", {31'd0, gnt0}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr", {27'd0, mem_addr}, 0);
        chk("rst_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_busy", {31'd0, clear_busy}, 0);
        chk("rst_done", {31'd0, clear_done}, 0);
        chk("rst_err", {31'd0, addr_err}, 0);
        req0 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Tie: req0 first after reset, then alternate.
        req0 = 1'b1; addr0 = 5'd1; data0 = 8'h10;
        req1 = 1'b1; addr1 = 5'd2; data1 = 8'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 1 : 0);
            chk("rr_gnt1", {31'd0, gnt1}, (i % 2 == 1) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(0, 5'd5, 8'h3C, w);
        chk("single_lat", w, 0);
        send(1, 5'd15, 8'h77, w);
        send(1, 5'd16, 8'h01, w);
        chk("err_gnt_lat", w, 0);
        send(0, 5'd31, 8'h02, w);
        for (int i = 0; i < 8; i++)
            send(i % 2, AW'($urandom_range(0, 31)), DW'($urandom), w);
        repeat (2) @(posedge clk);
        #1;

        // Fill with a requester waiting throughout.
        start_clear(8'hFF);
        send(0, 5'd3, 8'h55, w);
        chk("held_ungranted", w, 17);
        chk("busy_cycles", busy_cnt, 17);
        chk("done_once", done_cnt, 1);
        repeat (2) @(posedge clk);
        #1;

        // Grant alongside clear_start, then a restart attempt mid-fill.
        req1 = 1'b1; addr1 = 5'd9; data1 = 8'h99;
        start_clear(8'hA5);
        req1 = 1'b0;
        clear_start = 1'b1; clear_colour = 8'h11;
        @(posedge clk);
        #1 clear_start = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        chk("restart_done", done_cnt, 1);
        chk("restart_busy", busy_cnt, 17);

        // Reset with the fill counter at 7.
        start_clear(8'h33);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_we", {31'd0, mem_we}, 0);
        chk("abort_addr", {27'd0, mem_addr}, 0);
        chk("abort_wdata", {24'd0, mem_wdata}, 0);
        chk("abort_busy", {31'd0, clear_busy}, 0);
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        send(0, 5'd7, 8'hC3, w);
        chk("post_rst_lat", w, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("q_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
